// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-rate divider, H/V scan counters, registered sync/blank/coordinates, frame tick.
// Latency: every output is registered and reflects the counter values that take effect on the same Clk edge.
// Backpressure: none; free-running source, downstream must accept every pixel at the pix_en rate.
module vga_timing_gen #(
    parameter int PIX_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       pix_en,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Window bounds are 11 bits so an end bound equal to a 1024 total does not wrap to zero.
    localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] H_VIS_L = 11'(H_VIS);
    localparam logic [10:0] V_VIS_L = 11'(V_VIS);

    if (PIX_DIV < 1 || H_VIS < 1 || V_VIS < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
        $error("vga_timing_gen: PIX_DIV must be >= 1 and raster totals must fit 10-bit counters");
    end

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       hc;
    logic [9:0]       vc;
    logic [9:0]       hc_nxt;
    logic [9:0]       vc_nxt;
    logic             line_wrap;
    logic [10:0]      hx;
    logic [10:0]      vx;

    // Counters step on the edge that closes a pix_en cycle; sync/blank are decoded from the
    // post-edge counter values so all outputs move together.
    always_comb begin
        div_nxt   = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        line_wrap = pix_en && (hc == H_LAST);
        hc_nxt    = hc;
        vc_nxt    = vc;
        if (pix_en) begin
            hc_nxt = (hc == H_LAST) ? 10'd0 : hc + 10'd1;
        end
        if (line_wrap) begin
            vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end
        hx = {1'b0, hc_nxt};
        vx = {1'b0, vc_nxt};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div        <= '0;
            pix_en     <= 1'b0;
            hc         <= 10'd0;
            vc         <= 10'd0;
            hs         <= 1'b1;
            vs         <= 1'b1;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            div        <= div_nxt;
            pix_en     <= (div_nxt == DIV_LAST);
            hc         <= hc_nxt;
            vc         <= vc_nxt;
            hs         <= !((hx >= HS_BEG) && (hx < HS_END));
            vs         <= !((vx >= VS_BEG) && (vx < VS_END));
            blank      <= (hx < H_VIS_L) && (vx < V_VIS_L);
            // Only the line wrap into the first invisible line reaches (0, V_VIS).
            frame_tick <= line_wrap && (vx == V_VIS_L);
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three raster configurations scored every Clk against a closed-form timing model.
module tb_vga_timing_gen;

    typedef logic [24:0] vec_t;  // {frame_tick, pix_en, hs, vs, blank, DrawY, DrawX}

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;

    logic       a_pe, a_hs, a_vs, a_bl, a_tk;
    logic [9:0] a_x, a_y;
    logic       b_pe, b_hs, b_vs, b_bl, b_tk;
    logic [9:0] b_x, b_y;
    logic       c_pe, c_hs, c_vs, c_bl, c_tk;
    logic [9:0] c_x, c_y;

    vec_t a_vec, b_vec, c_vec;
    assign a_vec = {a_tk, a_pe, a_hs, a_vs, a_bl, a_y, a_x};
    assign b_vec = {b_tk, b_pe, b_hs, b_vs, b_bl, b_y, b_x};
    assign c_vec = {c_tk, c_pe, c_hs, c_vs, c_bl, c_y, c_x};

    vga_timing_gen u_a (
        .Clk(Clk), .Reset_n(Reset_n), .pix_en(a_pe), .hs(a_hs), .vs(a_vs), .blank(a_bl),
        .DrawX(a_x), .DrawY(a_y), .frame_tick(a_tk)
    );

    vga_timing_gen #(
        .PIX_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .pix_en(b_pe), .hs(b_hs), .vs(b_vs), .blank(b_bl),
        .DrawX(b_x), .DrawY(b_y), .frame_tick(b_tk)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .H_VIS(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_c (
        .Clk(Clk), .Reset_n(Reset_n), .pix_en(c_pe), .hs(c_hs), .vs(c_vs), .blank(c_bl),
        .DrawX(c_x), .DrawY(c_y), .frame_tick(c_tk)
    );

    vec_t qa[$];
    vec_t qb[$];
    vec_t qc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    // Expected outputs after the k-th Clk edge since reset release (k=0: still in reset).
    function automatic vec_t model(input int kk, input int d,
                                   input int hv, input int hfp, input int hsy, input int hbp,
                                   input int vv, input int vfp, input int vsy, input int vbp);
        int   ht;
        int   vt;
        int   p;
        int   hc;
        int   vc;
        logic pe, adv, hs, vs, bl, tk;
        ht = hv + hfp + hsy + hbp;
        vt = vv + vfp + vsy + vbp;
        if (kk == 0) return {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
        pe  = ((kk % d) == (d - 1));
        adv = (kk >= 2) && (((kk - 1) % d) == (d - 1));
        p   = (d == 1) ? kk - 1 : kk / d;
        hc  = p % ht;
        vc  = (p / ht) % vt;
        hs  = !(hc >= hv + hfp && hc < hv + hfp + hsy);
        vs  = !(vc >= vv + vfp && vc < vv + vfp + vsy);
        bl  = (hc < hv) && (vc < vv);
        tk  = adv && ((p % (ht * vt)) == vv * ht);
        return {tk, pe, hs, vs, bl, 10'(vc), 10'(hc)};
    endfunction

    task automatic run_phase(input int n);
        int   hs_low = 0;
        int   b_ticks = 0;
        int   c_ticks = 0;
        int   b_prev = 0;
        int   c_prev = 0;
        int   hold_viol = 0;
        int   sync_viol = 0;
        int   pe_low = 0;
        vec_t pa, pb;
        logic pea, peb;
        k   = 0;
        pa  = a_vec;
        pb  = b_vec;
        pea = a_pe;
        peb = b_pe;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            k++;
            qa.push_back(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33));
            qb.push_back(model(k, 2, 8, 2, 3, 2, 4, 1, 2, 1));
            qc.push_back(model(k, 1, 8, 1, 2, 1, 4, 1, 1, 1));
            @(negedge Clk);
            chk("a_outputs", a_vec, qa.pop_front());
            chk("b_outputs", b_vec, qb.pop_front());
            chk("c_outputs", c_vec, qc.pop_front());
            if (k <= 1600 && !a_hs) hs_low++;
            if (b_tk) begin
                chk("b_tick_pos", {b_y, b_x}, {10'd4, 10'd0});
                if (b_ticks > 0) chk("b_tick_gap", k - b_prev, 240);
                else chk("b_tick_first", k, 120);
                b_prev = k;
                b_ticks++;
            end
            if (c_tk) begin
                if (c_ticks > 0) chk("c_tick_gap", k - c_prev, 84);
                c_prev = k;
                c_ticks++;
            end
            if (!c_pe) pe_low++;
            if ((a_vec[22:0] != pa[22:0]) && !pea) hold_viol++;
            if ((b_vec[22:0] != pb[22:0]) && !peb) hold_viol++;
            if (a_bl && (!a_hs || !a_vs)) sync_viol++;
            if (b_bl && (!b_hs || !b_vs)) sync_viol++;
            if (c_bl && (!c_hs || !c_vs)) sync_viol++;
            pa  = a_vec;
            pb  = b_vec;
            pea = a_pe;
            peb = b_pe;
        end
        chk("a_hs_low_clks_line0", hs_low, 192);
        chk("b_tick_count", b_ticks, (n - 120) / 240 + 1);
        chk("c_tick_count", c_ticks, (n - 49) / 84 + 1);
        chk("c_pix_en_low_cycles", pe_low, 0);
        chk("hold_between_pix_en", hold_viol, 0);
        chk("blank_during_sync", sync_viol, 0);
    endtask

    vec_t rst_vec;

    initial begin
        rst_vec = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        chk("a_reset", a_vec, rst_vec);
        chk("b_reset", b_vec, rst_vec);
        chk("c_reset", c_vec, rst_vec);
        Reset_n = 1'b1;

        // 3800 edges leaves the default raster at DrawX=300 on line 2.
        run_phase(3800);
        chk("a_pre_reset_x", a_x, 10'd300);

        #2 Reset_n = 1'b0;
        #1;
        chk("a_async_reset", a_vec, rst_vec);
        chk("b_async_reset", b_vec, rst_vec);
        chk("c_async_reset", c_vec, rst_vec);
        repeat (3) @(negedge Clk);
        chk("a_reset_hold", a_vec, rst_vec);
        Reset_n = 1'b1;

        run_phase(3800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
